// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//   Shared types and constants for the ID-stage hazard detector.
//   - hz_state_t       : sequencer states (RUN, STALL, FREEZE)
//   - STALL_LOADUSE    : stall cycles for a load feeding an ALU consumer in ID
//   - STALL_LD_BRANCH  : stall cycles for a load feeding a branch compared in ID
//   - STALL_ALU_BRANCH : stall cycles for an ALU result (or a load already in
//                        MEM) feeding a branch compared in ID
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FREEZE = 2'd2
  } hz_state_t;

  localparam int STALL_LOADUSE    = 1;
  localparam int STALL_LD_BRANCH  = 2;
  localparam int STALL_ALU_BRANCH = 1;

endpackage

// File: rtl/hazard_perf_counter.sv
// -----------------------------------------------------------------------------
// hazard_perf_counter
//   Saturating event counter. It sticks at all-ones instead of wrapping.
//   Ports:
//     clk_i   : clock
//     clr_i   : synchronous clear (takes priority over inc_i)
//     inc_i   : count one event this cycle
//     count_o : current count
// -----------------------------------------------------------------------------
module hazard_perf_counter #(
  parameter int PERF_W = 32
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [PERF_W-1:0] count_o
);

  logic [PERF_W-1:0] count_q;
  logic [PERF_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_detect_unit.sv
// -----------------------------------------------------------------------------
// hazard_detect_unit
//   ID-stage hazard detector for the 5-stage MIPS pipeline. It stalls when
//   forwarding cannot resolve a RAW hazard (load-use, ID-resolved branch
//   operands). It freezes the whole pipe while data memory is busy.
//   Optional feature macro: HAZARD_PERF_EN (adds the stall/flush perf counters).
//   Ports:
//     clk_i, rst_i             : clock, synchronous active-high reset
//     IF_ID_RS_i/RT_i/UsesRT_i : source operands of the instruction in ID
//     IF_ID_Branch_i           : ID instruction is beq/bne
//     branch_taken_i           : ID comparator result
//     ID_EX_MemRead_i/RegWrite_i/Write_Reg_i : EX-stage producer
//     EX_MEM_MemRead_i/Write_Reg_i           : MEM-stage producer
//     dmem_busy_i              : data memory not ready
//     PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_bubble_o, pipe_freeze_o
//     stall_cycles_o, flush_count_o (HAZARD_PERF_EN only)
// -----------------------------------------------------------------------------
module hazard_detect_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 2,
  parameter int PERF_W     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] IF_ID_RS_i,
  input  logic [REG_ADDR_W-1:0] IF_ID_RT_i,
  input  logic                  IF_ID_UsesRT_i,
  input  logic                  IF_ID_Branch_i,
  input  logic                  branch_taken_i,
  input  logic                  ID_EX_MemRead_i,
  input  logic                  ID_EX_RegWrite_i,
  input  logic [REG_ADDR_W-1:0] ID_EX_Write_Reg_i,
  input  logic                  EX_MEM_MemRead_i,
  input  logic [REG_ADDR_W-1:0] EX_MEM_Write_Reg_i,
  input  logic                  dmem_busy_i,
  output logic                  PC_write_o,
  output logic                  IF_ID_write_o,
  output logic                  IF_ID_flush_o,
  output logic                  ID_EX_bubble_o,
  output logic                  pipe_freeze_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0]     stall_cycles_o,
  output logic [PERF_W-1:0]     flush_count_o
`endif
);

  if (CNT_W < 2 || PERF_W < 1) begin : g_param_check
    $error("hazard_detect_unit: CNT_W must be >= 2 and PERF_W >= 1");
  end

  hz_state_t        state_q;
  hz_state_t        ret_q;      // state to resume after a freeze
  hz_state_t        eff_state;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] need_n;
  logic             ex_match;
  logic             mem_match;
  logic             stall_now;
  logic             flush_now;

  // Register $0 is hard-wired, so it never produces a hazard.
  assign ex_match  = (ID_EX_Write_Reg_i != '0) &&
                     ((ID_EX_Write_Reg_i == IF_ID_RS_i) ||
                      (IF_ID_UsesRT_i && (ID_EX_Write_Reg_i == IF_ID_RT_i)));
  assign mem_match = (EX_MEM_Write_Reg_i != '0) &&
                     ((EX_MEM_Write_Reg_i == IF_ID_RS_i) ||
                      (IF_ID_UsesRT_i && (EX_MEM_Write_Reg_i == IF_ID_RT_i)));

  // The load rule already gives the larger count when it coincides with a
  // branch hazard, so first-match priority yields the maximum N.
  always_comb begin
    need_n = '0;
    if (ID_EX_MemRead_i && ex_match) begin
      need_n = IF_ID_Branch_i ? CNT_W'(STALL_LD_BRANCH) : CNT_W'(STALL_LOADUSE);
    end else if (IF_ID_Branch_i && ID_EX_RegWrite_i && ex_match) begin
      need_n = CNT_W'(STALL_ALU_BRANCH);
    end else if (IF_ID_Branch_i && EX_MEM_MemRead_i && mem_match) begin
      need_n = CNT_W'(STALL_ALU_BRANCH);
    end
  end

  // On the first non-busy cycle in FREEZE, the saved state acts immediately.
  // Treating FREEZE as its return state folds the exit case into the
  // normal RUN/STALL handling.
  assign eff_state = (state_q == FREEZE) ? ret_q : state_q;

  assign stall_now = !dmem_busy_i &&
                     ((eff_state == STALL) || ((eff_state == RUN) && (need_n != '0)));
  assign flush_now = !dmem_busy_i && (eff_state == RUN) && (need_n == '0) &&
                     IF_ID_Branch_i && branch_taken_i;

  // Outputs are combinational: a hazard stalls in the cycle it is detected.
  always_comb begin
    PC_write_o     = 1'b1;
    IF_ID_write_o  = 1'b1;
    ID_EX_bubble_o = 1'b0;
    IF_ID_flush_o  = 1'b0;
    pipe_freeze_o  = 1'b0;
    if (!rst_i) begin
      PC_write_o     = !dmem_busy_i && !stall_now;
      IF_ID_write_o  = !dmem_busy_i && !stall_now;
      ID_EX_bubble_o = stall_now;
      IF_ID_flush_o  = flush_now;
      pipe_freeze_o  = dmem_busy_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      ret_q   <= RUN;
      cnt_q   <= '0;
    end else if (dmem_busy_i) begin
      // Hold cnt. Remember where to go back only on entry, so a long
      // freeze does not overwrite the return state with FREEZE.
      if (state_q != FREEZE) begin
        ret_q <= state_q;
      end
      state_q <= FREEZE;
    end else if (eff_state == STALL) begin
      cnt_q   <= cnt_q - CNT_W'(1);
      state_q <= (cnt_q <= CNT_W'(1)) ? RUN : STALL;
    end else begin
      if (need_n != '0) begin
        cnt_q   <= need_n - CNT_W'(1);
        state_q <= (need_n > CNT_W'(1)) ? STALL : RUN;
      end else begin
        state_q <= RUN;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic stall_evt;
  logic flush_evt;

  assign stall_evt = !rst_i && (stall_now || dmem_busy_i);
  assign flush_evt = !rst_i && flush_now;

  hazard_perf_counter #(.PERF_W(PERF_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .clr_i   (rst_i),
    .inc_i   (stall_evt),
    .count_o (stall_cycles_o)
  );

  hazard_perf_counter #(.PERF_W(PERF_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .clr_i   (rst_i),
    .inc_i   (flush_evt),
    .count_o (flush_count_o)
  );
`endif

endmodule

// File: tb/tb_hazard_detect_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_detect_unit
//   Directed pipeline scenarios with literal expectations, then randomized
//   stimulus checked every cycle against a behavioural model. The model only
//   tracks "stall cycles still owed". It has no notion of FSM states.
//   Build with +define+HAZARD_PERF_EN to also check the perf counters.
// -----------------------------------------------------------------------------
module tb_hazard_detect_unit;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs, rt, ex_wr, mem_wr;
  logic       uses_rt, br, taken, ex_mr, ex_rw, mem_mr, busy;
  logic       pc_w, ifid_w, flush, bubble, freeze;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cyc, flush_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  hazard_detect_unit #(.REG_ADDR_W(5), .CNT_W(2), .PERF_W(32)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .IF_ID_RS_i         (rs),
    .IF_ID_RT_i         (rt),
    .IF_ID_UsesRT_i     (uses_rt),
    .IF_ID_Branch_i     (br),
    .branch_taken_i     (taken),
    .ID_EX_MemRead_i    (ex_mr),
    .ID_EX_RegWrite_i   (ex_rw),
    .ID_EX_Write_Reg_i  (ex_wr),
    .EX_MEM_MemRead_i   (mem_mr),
    .EX_MEM_Write_Reg_i (mem_wr),
    .dmem_busy_i        (busy),
    .PC_write_o         (pc_w),
    .IF_ID_write_o      (ifid_w),
    .IF_ID_flush_o      (flush),
    .ID_EX_bubble_o     (bubble),
    .pipe_freeze_o      (freeze)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles_o     (stall_cyc),
    .flush_count_o      (flush_cnt)
`endif
  );

  // ---------------- behavioural model ----------------
  int          owed = 0;          // stall cycles still owed after this one
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;

  function automatic bit reads(input logic [4:0] x);
    return (x != 5'd0) && ((x == rs) || (uses_rt && (x == rt)));
  endfunction

  function automatic int stall_needed();
    if (ex_mr && reads(ex_wr)) return br ? 2 : 1;
    if (br && ex_rw && reads(ex_wr)) return 1;
    if (br && mem_mr && reads(mem_wr)) return 1;
    return 0;
  endfunction

  // {PC_write, IF_ID_write, bubble, flush, freeze}
  function automatic logic [4:0] model_out();
    if (rst) return 5'b11000;
    if (busy) return 5'b00001;
    if (owed > 0 || stall_needed() > 0) return 5'b00100;
    return {3'b110, br && taken, 1'b0};
  endfunction

  always @(posedge clk) begin
    logic [4:0] e;
    e = model_out();
    if (rst) begin
      owed    = 0;
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (!busy) begin
        if (owed > 0) owed = owed - 1;
        else if (stall_needed() > 0) owed = stall_needed() - 1;
      end
      if ((e[2] || e[0]) && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (e[1] && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, required %0h", name, $time, got, want);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    logic [4:0] e;
    e = model_out();
    chk("model_pc_write", 32'(pc_w), 32'(e[4]));
    chk("model_ifid_write", 32'(ifid_w), 32'(e[3]));
    chk("model_bubble", 32'(bubble), 32'(e[2]));
    chk("model_flush", 32'(flush), 32'(e[1]));
    chk("model_freeze", 32'(freeze), 32'(e[0]));
`ifdef HAZARD_PERF_EN
    chk("model_stall_cycles", stall_cyc, m_stall);
    chk("model_flush_count", flush_cnt, m_flush);
`endif
  end

  // ---------------- directed helpers ----------------
  task automatic idle();
    rst = 0; rs = 0; rt = 0; uses_rt = 0; br = 0; taken = 0;
    ex_mr = 0; ex_rw = 0; ex_wr = 0; mem_mr = 0; mem_wr = 0; busy = 0;
  endtask

  // One transaction: inputs already applied; check literal outputs mid-cycle.
  task automatic cyc(input string name, input logic [4:0] want);
    logic [4:0] got;
    @(negedge clk);
    got = {pc_w, ifid_w, bubble, flush, freeze};
    chk(name, 32'(got), 32'(want));
    $display("txn %-20s pc/ifid/bub/flush/frz=%b expect=%b", name, got, want);
    @(posedge clk);
    #1;
  endtask

  task automatic lw2_beq();   // lw $2 in EX; beq $2,$3 (taken) in ID
    idle();
    ex_mr = 1; ex_rw = 1; ex_wr = 2; rs = 2; rt = 3; uses_rt = 1; br = 1; taken = 1;
  endtask

  task automatic lw2_in_mem(); // bubble in EX, the load moved on to MEM
    ex_mr = 0; ex_rw = 0; ex_wr = 0; mem_mr = 1; mem_wr = 2;
  endtask

  localparam logic [4:0] RUNV = 5'b11000, STALLV = 5'b00100,
                         FLUSHV = 5'b11010, FRZV = 5'b00001;

  initial begin
    idle();
    rst = 1;
    cyc("reset_a", RUNV);
    cyc("reset_b", RUNV);
    idle();
    cyc("idle", RUNV);

    // 1. load-use, single stall
    ex_mr = 1; ex_rw = 1; ex_wr = 2; rs = 2; rt = 5; uses_rt = 1;
    cyc("t1_stall", STALLV);
    ex_mr = 0; ex_rw = 0; ex_wr = 0; mem_mr = 1; mem_wr = 2;
    cyc("t1_resume", RUNV);

    // 2. load feeding a branch: two stalls, then flush on the taken branch
    lw2_beq();
    cyc("t2_stall1", STALLV);
    lw2_in_mem();
    cyc("t2_stall2", STALLV);
    mem_mr = 0; mem_wr = 0;
    cyc("t2_flush", FLUSHV);

    // 3. ALU result feeding a branch: one stall, then flush
    idle();
    ex_rw = 1; ex_wr = 4; rs = 4; rt = 0; uses_rt = 1; br = 1; taken = 1;
    cyc("t3_stall", STALLV);
    ex_rw = 0; ex_wr = 0; mem_wr = 4;
    cyc("t3_flush", FLUSHV);
    idle();
    cyc("t3_after", RUNV);

    // 4. $0 never hazards
    ex_mr = 1; ex_rw = 1; ex_wr = 0; rs = 0; rt = 0; uses_rt = 1;
    cyc("t4_zero_reg", RUNV);
    br = 1;
    cyc("t4_zero_branch", RUNV);

    // 5a. busy during cycle 1 of case 2: freeze x3, then both stalls
    lw2_beq();
    busy = 1;
    cyc("t5_freeze1", FRZV);
    cyc("t5_freeze2", FRZV);
    cyc("t5_freeze3", FRZV);
    busy = 0;
    cyc("t5_stall1", STALLV);
    lw2_in_mem();
    cyc("t5_stall2", STALLV);
    mem_mr = 0; mem_wr = 0;
    cyc("t5_flush", FLUSHV);

    // 5b. busy rising mid-STALL: the owed stall survives the freeze
    lw2_beq();
    cyc("t5b_stall1", STALLV);
    lw2_in_mem();
    busy = 1;
    cyc("t5b_freeze", FRZV);
    busy = 0;
    cyc("t5b_stall2", STALLV);
    mem_mr = 0; mem_wr = 0;
    cyc("t5b_flush", FLUSHV);

    // 6. reset during STALL abandons the sequence
    lw2_beq();
    cyc("t6_stall1", STALLV);
    lw2_in_mem();
    rst = 1;
    cyc("t6_in_reset", RUNV);
    idle();
`ifdef HAZARD_PERF_EN
    @(negedge clk);
    chk("t6_stall_cycles_zero", stall_cyc, 32'd0);
    chk("t6_flush_count_zero", flush_cnt, 32'd0);
`endif
    cyc("t6_after_reset", RUNV);
    ex_mr = 1; ex_rw = 1; ex_wr = 7; rs = 7;
    cyc("t6_one_stall", STALLV);
    idle();
`ifdef HAZARD_PERF_EN
    @(negedge clk);
    chk("t6_stall_cycles_one", stall_cyc, 32'd1);
`endif
    cyc("t6_idle", RUNV);

    // Randomized traffic; small register range to force frequent matches.
    for (int i = 0; i < 1500; i++) begin
      rst     = ($urandom_range(0, 99) < 2);
      rs      = 5'($urandom_range(0, 3));
      rt      = 5'($urandom_range(0, 3));
      uses_rt = 1'($urandom_range(0, 1));
      br      = 1'($urandom_range(0, 1));
      taken   = 1'($urandom_range(0, 1));
      ex_mr   = ($urandom_range(0, 99) < 30);
      ex_rw   = ($urandom_range(0, 99) < 60);
      ex_wr   = 5'($urandom_range(0, 3));
      mem_mr  = ($urandom_range(0, 99) < 30);
      mem_wr  = 5'($urandom_range(0, 3));
      busy    = ($urandom_range(0, 99) < 15);
      @(posedge clk);
      #1;
    end

    idle();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
